// File: rtl/ram_fifo_pkg.sv
// Shared widths and types for the RAM-backed FIFO controller.
// The pointer carries one extra lap bit above the RAM index.
package ram_fifo_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W:0]   ptr_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop handshake plus the RAM write/read port, bundled for the controller.
// Push is taken on a rising edge when Push=1 and Full=0; Pop is taken when Pop=1 and Empty=0;
// refused requests are dropped (not held) and only raise the sticky error flags.
interface ram_fifo_ctrl_if import ram_fifo_pkg::*; ();
  logic            Push;
  data_t           Push_data;
  logic            Full;
  logic            Pop;
  logic            Empty;
  logic            Pop_valid;
  data_t           Pop_data;
  logic [ADDR_W:0] Count;
  logic            Overflow;
  logic            Underflow;
  logic            Clr_err;
  logic            Ram_we;
  addr_t           Ram_wa;
  data_t           Ram_din;
  logic            Ram_re;
  addr_t           Ram_ra;
  data_t           Ram_dout;

  modport slave (
    input  Push, Push_data, Pop, Clr_err, Ram_dout,
    output Full, Empty, Pop_valid, Pop_data, Count, Overflow, Underflow,
           Ram_we, Ram_wa, Ram_din, Ram_re, Ram_ra
  );

  modport master (
    output Push, Push_data, Pop, Clr_err, Ram_dout,
    input  Full, Empty, Pop_valid, Pop_data, Count, Overflow, Underflow,
           Ram_we, Ram_wa, Ram_din, Ram_re, Ram_ra
  );
endinterface

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer: increments on Inc, rolls over modulo 2**(ADDR_W+1).
module fifo_ptr import ram_fifo_pkg::*; (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Inc,
  output ptr_t Ptr
);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Ptr <= '0;
    end else if (Inc) begin
      Ptr <= Ptr + ptr_t'(1);
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a 1-cycle-latency RAM; flags decoded from wrap-bit pointers.
// Read data is the raw RAM output, qualified by a registered Pop_valid.
module ram_fifo_ctrl import ram_fifo_pkg::*; (
  input logic            Clk,
  input logic            Rst_n,
  ram_fifo_ctrl_if.slave bus
);

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  logic full;
  logic empty;
  logic acc_w;
  logic acc_r;
  logic pop_valid;
  logic overflow;
  logic underflow;

  // Equal index with opposite lap bits means the writer is a full lap ahead.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  // Rst_n gating keeps the RAM strobes quiet during an asynchronous reset.
  assign acc_w = Rst_n & bus.Push & ~full;
  assign acc_r = Rst_n & bus.Pop & ~empty;

  fifo_ptr u_wr_ptr (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Inc   (acc_w),
    .Ptr   (wr_ptr)
  );

  fifo_ptr u_rd_ptr (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Inc   (acc_r),
    .Ptr   (rd_ptr)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= acc_r;
      // A new error in the same cycle as Clr_err takes priority over the clear.
      if (bus.Push && full) begin
        overflow <= 1'b1;
      end else if (bus.Clr_err) begin
        overflow <= 1'b0;
      end
      if (bus.Pop && empty) begin
        underflow <= 1'b1;
      end else if (bus.Clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  assign bus.Full      = full;
  assign bus.Empty     = empty;
  assign bus.Count     = wr_ptr - rd_ptr;
  assign bus.Pop_valid = pop_valid;
  assign bus.Pop_data  = bus.Ram_dout;
  assign bus.Overflow  = overflow;
  assign bus.Underflow = underflow;
  assign bus.Ram_we    = acc_w;
  assign bus.Ram_wa    = wr_ptr[ADDR_W-1:0];
  assign bus.Ram_din   = bus.Push_data;
  assign bus.Ram_re    = acc_r;
  assign bus.Ram_ra    = rd_ptr[ADDR_W-1:0];

endmodule
